// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUS  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    localparam logic OWN_IMEM = 1'b0;
    localparam logic OWN_DMEM = 1'b1;

    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Loadable down-counter with clear and enable; tc is high while the count is zero.
module mem_arb_watchdog #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             clear,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    // Clear has priority over load, load over counting; the count parks at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the CPU fetch and data ports onto one shared memory bus.
//
//   state    | meaning
//   ARB_IDLE | waiting for a request; arbitration happens here
//   ARB_BUS  | mem_req asserted, waiting for mem_ack or the watchdog
//   ARB_RESP | one-cycle ready pulse to the owning port
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_read_en,
    output logic [DATA_WIDTH-1:0] imem_read_data,
    output logic                  imem_ready,
    input  logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic [DATA_WIDTH-1:0] dmem_write_data,
    input  logic                  dmem_read_en,
    input  logic                  dmem_write_en,
    output logic [DATA_WIDTH-1:0] dmem_read_data,
    output logic                  dmem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_req,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_ack,
    output logic                  bus_error,
    output logic                  owner
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
    localparam logic [7:0] WD_LOAD    = 8'(TIMEOUT - 1);

    arb_state_e            state, state_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  we_q;
    logic                  owner_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] imem_rdata_q, dmem_rdata_q;
    logic [3:0]            starve_cnt;

    logic grant_dmem, grant_imem, capture, timeout, starving, wd_tc;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ARB_IDLE;
        else     state <= state_next;
    end

    // Next-state and arbitration decisions; dmem wins unless imem is starving.
    always_comb begin
        state_next = state;
        grant_dmem = 1'b0;
        grant_imem = 1'b0;
        capture    = 1'b0;
        timeout    = 1'b0;
        starving   = imem_read_en && (starve_cnt >= STARVE_LIM);
        unique case (state)
            ARB_IDLE: begin
                if ((dmem_read_en || dmem_write_en) && !starving) begin
                    grant_dmem = 1'b1;
                    state_next = ARB_BUS;
                end else if (imem_read_en) begin
                    grant_imem = 1'b1;
                    state_next = ARB_BUS;
                end
            end
            ARB_BUS: begin
                if (mem_ack) begin
                    capture    = 1'b1;
                    state_next = ARB_RESP;
                end else if (wd_tc) begin
                    timeout    = 1'b1;
                    state_next = ARB_RESP;
                end
            end
            ARB_RESP: state_next = ARB_IDLE;
            default:  state_next = ARB_IDLE;
        endcase
    end

    // Latch the granted request, track starvation and capture response data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            owner_q      <= OWN_IMEM;
            err_q        <= 1'b0;
            imem_rdata_q <= '0;
            dmem_rdata_q <= '0;
            starve_cnt   <= '0;
        end else begin
            if (grant_dmem) begin
                addr_q  <= dmem_addr;
                wdata_q <= dmem_write_data;
                we_q    <= dmem_write_en;
                owner_q <= OWN_DMEM;
                if (imem_read_en && (starve_cnt != 4'hF)) starve_cnt <= starve_cnt + 4'd1;
            end else if (grant_imem) begin
                addr_q     <= imem_addr;
                wdata_q    <= '0;
                we_q       <= 1'b0;
                owner_q    <= OWN_IMEM;
                starve_cnt <= '0;
            end
            if (capture) begin
                err_q <= 1'b0;
                if (owner_q == OWN_DMEM) dmem_rdata_q <= we_q ? '0 : mem_read_data;
                else                     imem_rdata_q <= we_q ? '0 : mem_read_data;
            end else if (timeout) begin
                err_q <= 1'b1;
                if (owner_q == OWN_DMEM) dmem_rdata_q <= DATA_WIDTH'(ERR_DATA);
                else                     imem_rdata_q <= DATA_WIDTH'(ERR_DATA);
            end
        end
    end

    mem_arb_watchdog #(.WIDTH(8)) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .load       (grant_dmem | grant_imem),
        .load_value (WD_LOAD),
        .enable     (state == ARB_BUS),
        .clear      (state == ARB_RESP),
        .tc         (wd_tc)
    );

    assign mem_req        = (state == ARB_BUS);
    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_we         = we_q;
    assign owner          = owner_q;
    assign imem_ready     = (state == ARB_RESP) && (owner_q == OWN_IMEM);
    assign dmem_ready     = (state == ARB_RESP) && (owner_q == OWN_DMEM);
    assign bus_error      = (state == ARB_RESP) && err_q;
    assign imem_read_data = imem_rdata_q;
    assign dmem_read_data = dmem_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_read_en;
    logic [31:0] imem_read_data;
    logic        imem_ready;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_write_data;
    logic        dmem_read_en;
    logic        dmem_write_en;
    logic [31:0] dmem_read_data;
    logic        dmem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_read_data;
    logic        mem_ack;
    logic        bus_error;
    logic        owner;

    int checks = 0;
    int errors = 0;

    // Memory model: acks in BUS cycle ack_at (1-based); ack_at = 0 never acks.
    int ack_at  = 0;
    int bus_cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst)                     bus_cyc <= 0;
        else if (mem_req && !mem_ack) bus_cyc <= bus_cyc + 1;
        else                          bus_cyc <= 0;
    end

    assign mem_ack = mem_req && (ack_at != 0) && (bus_cyc == ack_at - 1);

    mem_bus_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .imem_addr       (imem_addr),
        .imem_read_en    (imem_read_en),
        .imem_read_data  (imem_read_data),
        .imem_ready      (imem_ready),
        .dmem_addr       (dmem_addr),
        .dmem_write_data (dmem_write_data),
        .dmem_read_en    (dmem_read_en),
        .dmem_write_en   (dmem_write_en),
        .dmem_read_data  (dmem_read_data),
        .dmem_ready      (dmem_ready),
        .mem_addr        (mem_addr),
        .mem_write_data  (mem_write_data),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_read_data   (mem_read_data),
        .mem_ack         (mem_ack),
        .bus_error       (bus_error),
        .owner           (owner)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_addr = '0; imem_read_en = 1'b0;
        dmem_addr = '0; dmem_write_data = '0; dmem_read_en = 1'b0; dmem_write_en = 1'b0;
        mem_read_data = '0; ack_at = 0;
        #12;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        checks++; if ({imem_ready, dmem_ready, bus_error, owner, mem_we} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got=%b exp=00000", {imem_ready, dmem_ready, bus_error, owner, mem_we}); end
        checks++; if ({mem_addr, mem_write_data, imem_read_data, dmem_read_data} !== 128'h0) begin
            errors++; $display("FAIL reset_data got=%h %h %h %h exp=0", mem_addr, mem_write_data, imem_read_data, dmem_read_data); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single_fetch();
        imem_addr = 32'h100; imem_read_en = 1'b1; mem_read_data = 32'hE3A01005; ack_at = 1;
        tick();
        checks++; if ({mem_req, mem_we, owner} !== 3'b100 || mem_addr !== 32'h100) begin
            errors++; $display("FAIL fetch_bus got req/we/own=%b addr=%h exp=100 addr=100", {mem_req, mem_we, owner}, mem_addr); end
        checks++; if (imem_ready !== 1'b0) begin errors++; $display("FAIL fetch_early_ready got=%b exp=0", imem_ready); end
        tick();
        checks++; if (imem_ready !== 1'b1 || imem_read_data !== 32'hE3A01005 || mem_req !== 1'b0) begin
            errors++; $display("FAIL fetch_resp got rdy=%b data=%h req=%b exp=1 e3a01005 0", imem_ready, imem_read_data, mem_req); end
        imem_read_en = 1'b0;
        tick();
        checks++; if (imem_ready !== 1'b0 || imem_read_data !== 32'hE3A01005) begin
            errors++; $display("FAIL fetch_hold got rdy=%b data=%h exp=0 e3a01005", imem_ready, imem_read_data); end
    endtask

    task automatic test_simultaneous();
        imem_addr = 32'h200; imem_read_en = 1'b1;
        dmem_addr = 32'h8000; dmem_write_data = 32'h12345678; dmem_write_en = 1'b1;
        mem_read_data = 32'hAAAA5555; ack_at = 1;
        tick();
        checks++; if ({mem_req, mem_we, owner} !== 3'b111 || mem_addr !== 32'h8000 || mem_write_data !== 32'h12345678) begin
            errors++; $display("FAIL simul_dmem_bus got=%b addr=%h wd=%h exp=111 8000 12345678", {mem_req, mem_we, owner}, mem_addr, mem_write_data); end
        tick();
        checks++; if ({dmem_ready, imem_ready} !== 2'b10 || dmem_read_data !== 32'h0) begin
            errors++; $display("FAIL simul_dmem_resp got rdy=%b data=%h exp=10 00000000", {dmem_ready, imem_ready}, dmem_read_data); end
        dmem_write_en = 1'b0;
        tick();
        checks++; if ({mem_req, dmem_ready, imem_ready} !== 3'b000) begin
            errors++; $display("FAIL simul_idle got=%b exp=000", {mem_req, dmem_ready, imem_ready}); end
        tick();
        checks++; if ({mem_req, mem_we, owner} !== 3'b100 || mem_addr !== 32'h200) begin
            errors++; $display("FAIL simul_imem_bus got=%b addr=%h exp=100 200", {mem_req, mem_we, owner}, mem_addr); end
        tick();
        checks++; if ({imem_ready, dmem_ready} !== 2'b10 || imem_read_data !== 32'hAAAA5555) begin
            errors++; $display("FAIL simul_imem_resp got rdy=%b data=%h exp=10 aaaa5555", {imem_ready, dmem_ready}, imem_read_data); end
        imem_read_en = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        logic exp_own [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        imem_addr = 32'h400; imem_read_en = 1'b1;
        dmem_addr = 32'h300; dmem_read_en = 1'b1;
        mem_read_data = 32'h0F0F0F0F; ack_at = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (mem_req !== 1'b1 || owner !== exp_own[i]) begin
                errors++; $display("FAIL starve_owner_%0d got req=%b own=%b exp=1 %b", i, mem_req, owner, exp_own[i]); end
            tick();
            checks++; if ({dmem_ready, imem_ready} !== {exp_own[i], ~exp_own[i]}) begin
                errors++; $display("FAIL starve_ready_%0d got=%b exp=%b", i, {dmem_ready, imem_ready}, {exp_own[i], ~exp_own[i]}); end
            tick();
        end
        imem_read_en = 1'b0; dmem_read_en = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int n = 0;
        dmem_addr = 32'h500; dmem_read_en = 1'b1; ack_at = 0;
        tick();
        while (mem_req === 1'b1 && n < 100) begin
            n++;
            if (bus_error !== 1'b0 || dmem_ready !== 1'b0) begin
                errors++; $display("FAIL timeout_early got err=%b rdy=%b exp=0 0 at %0d", bus_error, dmem_ready, n); end
            tick();
        end
        checks++; if (n != 64) begin errors++; $display("FAIL timeout_len got=%0d exp=64", n); end
        checks++; if ({dmem_ready, bus_error} !== 2'b11 || dmem_read_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL timeout_resp got rdy/err=%b data=%h exp=11 deadbeef", {dmem_ready, bus_error}, dmem_read_data); end
        dmem_read_en = 1'b0;
        tick();
        checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL timeout_pulse got=%b exp=0", bus_error); end
    endtask

    task automatic test_ack_on_timeout();
        int n = 0;
        dmem_addr = 32'h600; dmem_read_en = 1'b1; mem_read_data = 32'h0BADF00D; ack_at = 64;
        tick();
        while (mem_req === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        checks++; if (n != 64) begin errors++; $display("FAIL acklast_len got=%0d exp=64", n); end
        checks++; if ({dmem_ready, bus_error} !== 2'b10 || dmem_read_data !== 32'h0BADF00D) begin
            errors++; $display("FAIL acklast_resp got rdy/err=%b data=%h exp=10 0badf00d", {dmem_ready, bus_error}, dmem_read_data); end
        dmem_read_en = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        imem_addr = 32'h700; imem_read_en = 1'b1; ack_at = 0;
        tick(); tick(); tick();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_pre got=%b exp=1", mem_req); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_async got=%b exp=0", mem_req); end
        imem_read_en = 1'b0;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (imem_ready !== 1'b0 || mem_req !== 1'b0) seen++;
            tick();
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_no_ready got=%0d exp=0", seen); end
        imem_addr = 32'h104; imem_read_en = 1'b1; mem_read_data = 32'h11112222; ack_at = 2;
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h104) begin
            errors++; $display("FAIL rstmid_next_bus got req=%b addr=%h exp=1 104", mem_req, mem_addr); end
        tick();
        tick();
        checks++; if (imem_ready !== 1'b1 || imem_read_data !== 32'h11112222 || bus_error !== 1'b0) begin
            errors++; $display("FAIL rstmid_next_resp got rdy=%b data=%h err=%b exp=1 11112222 0", imem_ready, imem_read_data, bus_error); end
        imem_read_en = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_timeout();
        test_ack_on_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=stuck exp=finish");
        $fatal(1, "bench time limit reached");
    end

endmodule
